fifo_rd_stream: RTL and testbench

- Read-side adapter placed directly downstream of the async FIFO, in the read clock domain.
- Converts the FIFO's rd_en/empty/registered-read interface (data valid 1 cycle after rd_en) into a valid/ready stream.
- Prefetches into a small local buffer so the stream sustains 1 word/cycle with no combinational path from m_ready_i to the FIFO read enable.

---
 rtl/fifo_rd_stream.sv | 104 ++++++++++
 tb/tb_fifo_rd_stream.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side prefetch adapter: async FIFO rd_en/empty port to a valid/ready stream.
// Optional statistics ports (word_cnt_o, stall_o) under FIFO_RD_STREAM_STAT_EN.
module fifo_rd_stream #(
   parameter int DLY            = 1,
   parameter int DATA_WIDTH     = 8,
   parameter int PREFETCH_DEPTH = 4
) (
   input  logic                                  clk_i,
   input  logic                                  rst_n_i,
   input  logic                                  fifo_empty_i,
   input  logic [DATA_WIDTH-1:0]                 fifo_data_i,
   output logic                                  fifo_rd_en_o,
   input  logic                                  flush_i,
   output logic                                  m_valid_o,
   output logic [DATA_WIDTH-1:0]                 m_data_o,
   input  logic                                  m_ready_i,
   output logic [$clog2(PREFETCH_DEPTH+1)-1:0]   level_o
`ifdef FIFO_RD_STREAM_STAT_EN
   ,
   output logic [31:0]                           word_cnt_o,
   output logic                                  stall_o
`endif
);

   localparam int CW = $clog2(PREFETCH_DEPTH + 1);
   localparam int PW = $clog2(PREFETCH_DEPTH);
   localparam logic [CW:0]   OCC_MAX  = (CW + 1)'(PREFETCH_DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(PREFETCH_DEPTH - 1);

   // DLY is carried for drop-in compatibility; registers here are delay-free.
   if (PREFETCH_DEPTH < 3 || PREFETCH_DEPTH > 16 || DLY < 0) begin : g_param_err
      $error("fifo_rd_stream: illegal parameter value");
   end

   logic [DATA_WIDTH-1:0] mem [PREFETCH_DEPTH];
   logic [CW-1:0]         cnt_q;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  inflight_q;
   logic                  drop_q;
   logic [CW:0]           occ;
   logic                  capture;
   logic                  pop;

   assign occ     = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};
   assign capture = inflight_q && !drop_q;
   assign pop     = m_valid_o && m_ready_i;

   // Issue depends on registered occupancy only, never on m_ready_i.
   assign fifo_rd_en_o = !fifo_empty_i && !flush_i && (occ < OCC_MAX);

   assign m_valid_o = (cnt_q != '0);
   assign m_data_o  = m_valid_o ? mem[rd_ptr] : '0;
   assign level_o   = cnt_q;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         inflight_q <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         inflight_q <= fifo_rd_en_o;
         if (flush_i) begin
            cnt_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            drop_q <= inflight_q;
         end else begin
            drop_q <= 1'b0;
            if (capture) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            unique case (1'b1)
               capture && !pop: cnt_q <= cnt_q + 1'b1;
               pop && !capture: cnt_q <= cnt_q - 1'b1;
               default:         cnt_q <= cnt_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (capture && !flush_i) mem[wr_ptr] <= fifo_data_i;
   end

`ifdef FIFO_RD_STREAM_STAT_EN
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         word_cnt_o <= '0;
         stall_o    <= 1'b0;
      end else begin
         if (flush_i)  word_cnt_o <= '0;
         else if (pop) word_cnt_o <= word_cnt_o + 32'd1;
         if (m_valid_o && !m_ready_i) stall_o <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed self-checking bench for fifo_rd_stream with a registered-read FIFO model.
// Define FIFO_RD_STREAM_STAT_EN to also exercise the statistics ports.
module tb_fifo_rd_stream;

   logic       clk_i = 1'b0;
   logic       rst_n_i;
   logic       fifo_empty_i;
   logic [7:0] fifo_data_i = '0;
   logic       fifo_rd_en_o;
   logic       flush_i;
   logic       m_valid_o;
   logic [7:0] m_data_o;
   logic       m_ready_i;
   logic [2:0] level_o;
`ifdef FIFO_RD_STREAM_STAT_EN
   logic [31:0] word_cnt_o;
   logic        stall_o;
`endif

   fifo_rd_stream dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .fifo_empty_i (fifo_empty_i),
      .fifo_data_i  (fifo_data_i),
      .fifo_rd_en_o (fifo_rd_en_o),
      .flush_i      (flush_i),
      .m_valid_o    (m_valid_o),
      .m_data_o     (m_data_o),
      .m_ready_i    (m_ready_i),
      .level_o      (level_o)
`ifdef FIFO_RD_STREAM_STAT_EN
      ,
      .word_cnt_o   (word_cnt_o),
      .stall_o      (stall_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   // FIFO model: data appears the cycle after rd_en.
   logic [7:0] mem [256];
   int head = 0;
   int tail = 0;
   assign fifo_empty_i = (head == tail);

   always @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         head <= tail;
      end else if (fifo_rd_en_o) begin
         fifo_data_i <= mem[head & 255];
         head        <= head + 1;
      end
   end

   int rd_cnt = 0;
   int bad_rd = 0;
   always @(posedge clk_i) begin
      if (fifo_rd_en_o) rd_cnt <= rd_cnt + 1;
      if (fifo_rd_en_o && fifo_empty_i) bad_rd <= bad_rd + 1;
   end

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic [7:0] v);
      mem[tail & 255] = v;
      tail = tail + 1;
   endtask

   initial begin
      int rd_base;
      rst_n_i   = 1'b0;
      flush_i   = 1'b0;
      m_ready_i = 1'b1;
      #1;
      chk("rst_valid", 32'(m_valid_o), 32'd0);
      chk("rst_level", 32'(level_o), 32'd0);
      chk("rst_data", 32'(m_data_o), 32'd0);
      chk("rst_rden", 32'(fifo_rd_en_o), 32'd0);
      tick();
      tick();
      rst_n_i = 1'b1;
      tick();

      // Basic: three words, ready high
      push(8'h11);
      push(8'h22);
      push(8'h33);
      #1;
      chk("basic_issue", 32'(fifo_rd_en_o), 32'd1);
      tick();
      chk("basic_lat1", 32'(m_valid_o), 32'd0);
      tick();
      chk("basic_w0", {m_valid_o, m_data_o}, {1'b1, 8'h11});
      tick();
      chk("basic_w1", {m_valid_o, m_data_o}, {1'b1, 8'h22});
      tick();
      chk("basic_w2", {m_valid_o, m_data_o}, {1'b1, 8'h33});
      tick();
      chk("basic_drain", {m_valid_o, 5'd0, level_o}, 32'd0);

      // Throughput: 64 words back-to-back
      for (int i = 0; i < 64; i++) push(8'(i * 3 + 1));
      tick();
      tick();
      for (int i = 0; i < 64; i++) begin
         chk($sformatf("tput_%0d", i), {m_valid_o, m_data_o},
             {1'b1, 8'(i * 3 + 1)});
         tick();
      end
      chk("tput_drain", 32'(m_valid_o), 32'd0);
      chk("tput_no_rd_empty", bad_rd, 32'd0);

      // Backpressure: 10 words, consumer stalled
      m_ready_i = 1'b0;
      rd_base   = rd_cnt;
      for (int i = 0; i < 10; i++) push(8'(8'hA0 + i));
      tick();
      tick();
      chk("bp_hold_early", {m_valid_o, m_data_o}, {1'b1, 8'hA0});
      for (int i = 0; i < 6; i++) tick();
      chk("bp_rd_count", rd_cnt - rd_base, 32'd4);
      chk("bp_level", 32'(level_o), 32'd4);
      chk("bp_hold_late", {m_valid_o, m_data_o}, {1'b1, 8'hA0});
      chk("bp_no_rden", 32'(fifo_rd_en_o), 32'd0);
      m_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("bp_w%0d", i), {m_valid_o, m_data_o},
             {1'b1, 8'(8'hA0 + i)});
         tick();
      end
      chk("bp_drain", 32'(m_valid_o), 32'd0);

      // Flush with a beat in flight
      m_ready_i = 1'b0;
      for (int i = 0; i < 6; i++) push(8'(8'hC0 + i));
      tick();
      tick();
      chk("fl_pre_level", 32'(level_o), 32'd1);
      flush_i   = 1'b1;
      m_ready_i = 1'b1;
      #1;
      chk("fl_rden_blocked", 32'(fifo_rd_en_o), 32'd0);
      tick();
      flush_i = 1'b0;
      chk("fl_post", {m_valid_o, 5'd0, level_o}, 32'd0);
      tick();
      tick();
      for (int i = 2; i < 6; i++) begin
         chk($sformatf("fl_w%0d", i), {m_valid_o, m_data_o},
             {1'b1, 8'(8'hC0 + i)});
         tick();
      end
      chk("fl_drain", 32'(m_valid_o), 32'd0);

      // Asynchronous reset with three words buffered
      m_ready_i = 1'b0;
      push(8'hE0);
      push(8'hE1);
      push(8'hE2);
      for (int i = 0; i < 4; i++) tick();
      chk("ar_level", 32'(level_o), 32'd3);
      #2;
      rst_n_i = 1'b0;
      #1;
      chk("ar_out", {fifo_rd_en_o, m_valid_o, m_data_o, 1'b0, level_o},
          32'd0);
      tick();
      rst_n_i   = 1'b1;
      m_ready_i = 1'b1;
      push(8'hF0);
      push(8'hF1);
      tick();
      tick();
      chk("ar_w0", {m_valid_o, m_data_o}, {1'b1, 8'hF0});
      tick();
      chk("ar_w1", {m_valid_o, m_data_o}, {1'b1, 8'hF1});
      tick();
      chk("ar_drain", 32'(m_valid_o), 32'd0);

`ifdef FIFO_RD_STREAM_STAT_EN
      chk("st_cnt_after_rst", word_cnt_o, 32'd2);
      chk("st_stall_after_rst", 32'(stall_o), 32'd0);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("st_cnt_flush0", word_cnt_o, 32'd0);
      m_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) push(8'(8'h51 + i));
      for (int i = 0; i < 3; i++) tick();
      m_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      chk("st_cnt5", word_cnt_o, 32'd5);
      chk("st_stall", 32'(stall_o), 32'd1);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("st_cnt_flush", word_cnt_o, 32'd0);
      chk("st_stall_sticky", 32'(stall_o), 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
